// File: rtl/rf_wb_if.sv
// rf_wb_if: writeback bus between two requesters and the register-file write port.
//   req0_* : requester 0 (ALU) valid/reg/data in, ready out
//   req1_* : requester 1 (load unit) valid/reg/data in, ready out
//   regwrite/wrreg/wrdata : registered register-file write port
//   pending : bit r set while a write to r is accepted but not yet issued
interface rf_wb_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic [4:0]      req0_reg;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [4:0]      req1_reg;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;
    logic            regwrite;
    logic [4:0]      wrreg;
    logic [XLEN-1:0] wrdata;
    logic [31:0]     pending;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  regwrite, wrreg, wrdata, pending
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output regwrite, wrreg, wrdata, pending
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter merging two writeback requesters onto one register-file write port.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   bus          : rf_wb_if slave (requester handshakes, write port, pending mask)
//   conflict_cnt : saturating count of cycles with both requesters valid
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_wb_if.slave        bus,
    output logic [CW-1:0] conflict_cnt
);
    logic            last_grant;
    logic            both;
    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic            wr_en;
    logic [4:0]      take_reg;
    logic [XLEN-1:0] take_data;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic            regwrite;
    logic [4:0]      wrreg;
    logic [XLEN-1:0] wrdata;
    logic [31:0]     pending;

    // last_grant=1 means port 1 won last, so port 0 wins the next conflict.
    // Readies are held low while reset is asserted.
    always_comb begin
        both      = bus.req0_valid & bus.req1_valid;
        grant0    = rst_n & bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1    = rst_n & bus.req1_valid & (~bus.req0_valid | ~last_grant);
        xfer      = grant0 | grant1;
        take_reg  = grant1 ? bus.req1_reg : bus.req0_reg;
        take_data = grant1 ? bus.req1_data : bus.req0_data;
        // Writes to x0 complete the handshake but never reach the register file.
        wr_en     = xfer & (take_reg != 5'd0);
        set_mask  = wr_en ? (32'd1 << take_reg) : 32'd0;
        clr_mask  = regwrite ? (32'd1 << wrreg) : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            regwrite     <= 1'b0;
            wrreg        <= 5'd0;
            wrdata       <= '0;
            pending      <= 32'd0;
            conflict_cnt <= '0;
        end else begin
            if (xfer)
                last_grant <= grant1;
            regwrite <= wr_en;
            if (wr_en) begin
                wrreg  <= take_reg;
                wrdata <= take_data;
            end
            // Set after clear so a new write to the retiring register keeps its bit.
            pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
            if (both && conflict_cnt != {CW{1'b1}})
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.regwrite   = regwrite;
    assign bus.wrreg      = wrreg;
    assign bus.wrdata     = wrdata;
    assign bus.pending    = pending;
endmodule
